// File: rtl/vector_mem_pkg.sv
// rtl/vector_mem_pkg.sv - shared types and sizes for the vector memory arbiter
package vector_mem_pkg;

  typedef enum logic { OWN_A = 1'b0, OWN_B = 1'b1 } owner_e;
  typedef enum logic { ST_IDLE = 1'b0, ST_BURST = 1'b1 } state_e;

  localparam int VMEM_ADDR_W = 9;
  localparam int VMEM_DATA_W = 128;

endpackage

// File: rtl/vector_mem_arbiter.sv
// rtl/vector_mem_arbiter.sv - shares the single-port vector memory between the VPU
// load/store unit (single beats) and the vector DMA engine (incrementing bursts).
module vector_mem_arbiter
  import vector_mem_pkg::*;
#(
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int DATA_W = VMEM_DATA_W,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LEN_W-1:0]  b_len,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_e             state_q, state_d;
  owner_e             last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               we_q, we_d;
  logic               rd_valid_q, rd_valid_d;
  owner_e             rd_owner_q, rd_owner_d;
  logic               grant_a, grant_b;

  // On a tie the requester that did not win last time goes first.
  assign grant_a = (state_q == ST_IDLE) && a_req && (!b_req || last_owner_q == OWN_B);
  assign grant_b = (state_q == ST_IDLE) && b_req && !grant_a;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    we_d         = we_q;
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_addr       = cnt_q;
    m_wdata      = b_wdata;
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    b_done       = 1'b0;

    if (grant_a) begin
      m_en         = 1'b1;
      m_we         = a_we;
      m_addr       = a_addr;
      m_wdata      = a_wdata;
      a_gnt        = 1'b1;
      last_owner_d = OWN_A;
    end else if (grant_b) begin
      m_en         = 1'b1;
      m_we         = b_we;
      m_addr       = b_addr;
      b_gnt        = 1'b1;
      last_owner_d = OWN_B;
      cnt_d        = b_addr + ADDR_ONE;
      rem_d        = b_len;
      we_d         = b_we;
      if (b_len == '0) begin
        b_done = 1'b1;
      end else begin
        state_d = ST_BURST;
      end
    end else if (state_q == ST_BURST && b_req) begin
      m_en  = 1'b1;
      m_we  = we_q;
      b_gnt = 1'b1;
      cnt_d = cnt_q + ADDR_ONE;
      rem_d = rem_q - LEN_ONE;
      if (rem_q == LEN_ONE) begin
        b_done  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // Tag each read so the returning word goes to the requester that issued it.
  assign rd_valid_d = m_en && !m_we;
  assign rd_owner_d = a_gnt ? OWN_A : OWN_B;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_B;
      cnt_q        <= '0;
      rem_q        <= '0;
      we_q         <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= OWN_A;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      we_q         <= we_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign a_rvalid = rd_valid_q && (rd_owner_q == OWN_A);
  assign b_rvalid = rd_valid_q && (rd_owner_q == OWN_B);
  assign a_rdata  = m_rdata;
  assign b_rdata  = m_rdata;

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// tb/tb_vector_mem_arbiter.sv - scoreboard bench for vector_mem_arbiter with a
// transaction-level reference model and a behavioural single-port memory.
module tb_vector_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_req, a_we, a_gnt, a_rvalid;
  logic [8:0]   a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic         b_req, b_we, b_gnt, b_done, b_rvalid;
  logic [8:0]   b_addr;
  logic [3:0]   b_len;
  logic [127:0] b_wdata, b_rdata;
  logic         m_en, m_we;
  logic [8:0]   m_addr;
  logic [127:0] m_wdata, m_rdata;

  vector_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] d; int due; } rd_t;

  logic [127:0] mem     [512];
  logic [127:0] ref_mem [512];
  rd_t          a_q[$], b_q[$];
  int           burst_q[$];
  bit           burst_we, last_a, armed, live;
  int           cyc, n_checks, n_pass;

  task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  // Reference model: the DMA burst is a queue of pending beat addresses.
  always @(negedge clk) begin
    bit ea, eb, ed, ewe;
    int eaddr;
    logic [127:0] ewd;
    rd_t e;
    if (!armed) begin
      armed = rst;
    end else begin
      live = 1;
      ea = 0; eb = 0; ed = 0; ewe = 0; eaddr = 0; ewd = '0;
      if (burst_q.size() != 0) begin
        if (b_req) begin
          eb = 1; eaddr = burst_q.pop_front(); ewe = burst_we; ewd = b_wdata;
          ed = (burst_q.size() == 0);
        end
      end else if (a_req && (!b_req || !last_a)) begin
        ea = 1; eaddr = int'(a_addr); ewe = a_we; ewd = a_wdata; last_a = 1;
      end else if (b_req) begin
        eb = 1; eaddr = int'(b_addr); ewe = b_we; ewd = b_wdata; burst_we = b_we; last_a = 0;
        for (int i = 1; i <= int'(b_len); i++) burst_q.push_back((int'(b_addr) + i) % 512);
        ed = (b_len == 4'd0);
      end
      check("a_gnt", a_gnt, ea);
      check("b_gnt", b_gnt, eb);
      check("b_done", b_done, ed);
      check("m_en", m_en, ea | eb);
      if (ea || eb) begin
        check("m_we", m_we, ewe);
        check("m_addr", m_addr, eaddr);
        if (ewe) begin
          check("m_wdata", m_wdata, ewd);
          ref_mem[eaddr] = ewd;
        end else if (!rst) begin
          e.d = ref_mem[eaddr]; e.due = cyc + 1;
          if (ea) a_q.push_back(e);
          else    b_q.push_back(e);
        end
      end
      if (rst) begin
        burst_q.delete();
        last_a = 0;
      end
    end
  end

  // Monitor: read returns are popped from the scoreboard when due.
  always @(negedge clk) begin
    bit exp_v;
    rd_t e;
    #1;
    if (live) begin
      exp_v = (a_q.size() != 0 && a_q[0].due == cyc);
      check("a_rvalid", a_rvalid, exp_v);
      if (exp_v) begin e = a_q.pop_front(); check("a_rdata", a_rdata, e.d); end
      exp_v = (b_q.size() != 0 && b_q[0].due == cyc);
      check("b_rvalid", b_rvalid, exp_v);
      if (exp_v) begin e = b_q.pop_front(); check("b_rdata", b_rdata, e.d); end
    end
  end

  bit ga, gb, gd;

  task automatic cycle();
    @(negedge clk);
    ga = a_gnt; gb = b_gnt; gd = b_done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1; a_req = 0; b_req = 0;
    repeat (n) cycle();
    rst = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int beats;
    bit b_act;
    for (int i = 0; i < 512; i++) begin
      mem[i] = rnd128(); ref_mem[i] = mem[i];
    end
    mem[5] = {16{8'hAA}}; ref_mem[5] = mem[5];
    a_we = 0; a_addr = 0; a_wdata = '0; b_we = 0; b_addr = 0; b_len = 0; b_wdata = '0;
    m_rdata = '0;
    @(posedge clk); #1;
    do_reset(3);
    cycle();

    // A read at address 5
    a_req = 1; a_we = 0; a_addr = 9'd5;
    cycle();
    check("a_gnt_addr5", {ga, gb}, 2'b10);
    a_req = 0;
    repeat (2) cycle();

    // tie right after reset, then both held continuously
    do_reset(2);
    a_req = 1; a_we = 0; a_addr = 9'($urandom);
    b_req = 1; b_we = 0; b_addr = 9'($urandom); b_len = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("tie_alternate", {ga, gb}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (ga) a_addr = 9'($urandom);
      if (gb) b_addr = 9'($urandom);
    end
    a_req = 0; b_req = 0;
    repeat (2) cycle();

    // write burst wrapping 510..1, A request raised mid-burst
    b_req = 1; b_we = 1; b_addr = 9'd510; b_len = 4'd3; b_wdata = rnd128();
    beats = 0;
    for (int k = 0; k < 20 && (a_req || b_req || k == 0); k++) begin
      cycle();
      if (gb) beats++;
      b_wdata = rnd128();
      if (beats == 2 && !gd && !ga) begin a_req = 1; a_we = 0; a_addr = 9'd0; end
      if (gd) b_req = 0;
      if (ga) a_req = 0;
    end
    check("burst_beats", beats, 4);
    repeat (2) cycle();

    // read burst of 3 with b_req low for 2 cycles after beat 0
    b_req = 1; b_we = 0; b_addr = 9'($urandom); b_len = 4'd2;
    cycle();
    b_req = 0;
    repeat (2) cycle();
    b_req = 1;
    for (int k = 0; k < 10 && b_req; k++) begin
      cycle();
      if (gd) b_req = 0;
    end
    repeat (2) cycle();

    // A read then B single-beat read on the next cycle
    a_req = 1; a_we = 0; a_addr = 9'($urandom);
    cycle();
    a_req = 0; b_req = 1; b_we = 0; b_addr = 9'($urandom); b_len = 0;
    cycle();
    b_req = 0;
    repeat (2) cycle();

    // reset during beat 2 of a 16-beat burst
    b_req = 1; b_we = 1; b_addr = 9'd100; b_len = 4'd15; b_wdata = rnd128();
    beats = 0;
    for (int k = 0; k < 10 && beats < 2; k++) begin
      cycle();
      if (gb) beats++;
      b_wdata = rnd128();
    end
    rst = 1;
    cycle();
    rst = 0; b_req = 0;
    cycle();
    b_req = 1; b_we = 0; b_addr = 9'd300; b_len = 4'd1;
    for (int k = 0; k < 10 && b_req; k++) begin
      cycle();
      if (gd) b_req = 0;
    end
    repeat (2) cycle();

    // randomized traffic
    b_act = 0;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      if (!a_req || ga) begin
        a_req = ($urandom % 2) != 0; a_we = ($urandom % 2) != 0;
        a_addr = 9'($urandom); a_wdata = rnd128();
      end
      if (gb && !gd) b_act = 1;
      if (gd) b_act = 0;
      if (b_act) begin
        b_req = ($urandom % 4) != 0; b_wdata = rnd128();
        b_addr = 9'($urandom); b_len = 4'($urandom); b_we = ($urandom % 2) != 0;
      end else if (!b_req || gb) begin
        b_req = ($urandom % 2) != 0; b_we = ($urandom % 2) != 0;
        b_addr = 9'($urandom); b_len = 4'($urandom); b_wdata = rnd128();
      end
    end

    // drain
    a_req = 0;
    if (!b_act) b_req = 0;
    else        b_req = 1;
    for (int k = 0; k < 40 && b_act; k++) begin
      cycle();
      b_wdata = rnd128();
      if (gd) begin b_act = 0; b_req = 0; end
    end
    check("drain_burst_done", b_act, 1'b0);
    b_req = 0;
    repeat (3) cycle();
    check("a_q_empty", a_q.size(), 0);
    check("b_q_empty", b_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_mem_arbiter.md
Name: vector_mem_arbiter

Overview:
- Shares the single-port 8KB vector data memory (512 x 128-bit, 1-cycle read latency) between two requesters: the VPU load/store unit (port A, single-beat) and the vector DMA engine (port B, incrementing bursts).
- Sits between both masters and the vector memory controller.
- Drives the memory enable/write/address/data lines and routes read data back to whichever requester issued the read.

Parameters:
- ADDR_W, 9, memory word address width (512 entries).
- DATA_W, 128, memory word width.
- LEN_W, 4, burst length field width; a burst is b_len+1 beats (1..16).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- a_req  in  1  VPU access request, held until a_gnt.
- a_we  in  1  VPU write (1) / read (0).
- a_addr  in  ADDR_W  VPU word address.
- a_wdata  in  DATA_W  VPU write data.
- a_gnt  out  1  VPU beat issued to memory this cycle.
- a_rvalid  out  1  VPU read data valid.
- a_rdata  out  DATA_W  VPU read data.
- b_req  in  1  DMA request; during a burst it also acts as the per-beat valid.
- b_we  in  1  DMA burst direction (write 1 / read 0).
- b_addr  in  ADDR_W  DMA burst start address.
- b_len  in  LEN_W  DMA burst beats minus one.
- b_wdata  in  DATA_W  DMA write data for the current beat.
- b_gnt  out  1  DMA beat issued this cycle; b_wdata is consumed.
- b_done  out  1  pulse coincident with the final beat's b_gnt.
- b_rvalid  out  1  DMA read data valid.
- b_rdata  out  DATA_W  DMA read data.
- m_en  out  1  memory enable.
- m_we  out  1  memory write.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_en with m_we=0.

Behaviour:
- FSM states: IDLE and BURST. Registers: state, last_owner (A/B), burst address counter, beats-remaining counter, latched b_we, rd_tag (valid, owner).
- Reset (clk edge with rst=1): state=IDLE, last_owner=B (A wins the first tie), counters=0, rd_tag cleared.
  - Consequence: all of m_en, m_we, a_gnt, b_gnt, b_done, a_rvalid and b_rvalid are 0 in the cycle after reset.
  - m_addr and m_wdata are don't-care while m_en=0.
- m_* and *_gnt are combinational from state and requests: the grant and the memory issue happen in the same cycle.
- IDLE arbitration:
  - Only a_req: A granted.
  - Only b_req: B granted.
  - Both: the owner not equal to last_owner is granted.
  - Granted owner is written to last_owner.
- A grant: m_en=1, m_we=a_we, m_addr=a_addr, m_wdata=a_wdata, a_gnt=1; state stays IDLE.
- B grant in IDLE issues beat 0 at b_addr; counter<=b_addr+1, remaining<=b_len, b_we latched.
  - b_len=0: b_done=1 and state stays IDLE.
  - Otherwise go to BURST.
- BURST:
  - No arbitration; a_req waits and a_gnt=0.
  - Each cycle with b_req=1: issue beat at counter with latched we, b_gnt=1, counter+1, remaining-1.
  - Cycle with b_req=0: stall; m_en=0, counters hold.
  - Beat issued with remaining=1: b_done=1, next state IDLE.
  - b_addr, b_len and b_we are ignored in BURST.
- Address arithmetic is modulo 2^ADDR_W: a burst from 510 with b_len=3 hits 510, 511, 0, 1.
- Read return:
  - rd_tag is registered on every read issue (m_en=1, m_we=0).
  - Next cycle: a_rvalid or b_rvalid = 1 per tag owner, for exactly one cycle.
  - a_rdata and b_rdata both equal m_rdata.
  - Writes produce no rvalid.
- Back-to-back: an A read at cycle n followed by a B read at n+1 gives a_rvalid at n+1 and b_rvalid at n+2; there are no bubbles.
- Reset mid-burst: burst abandoned; m_en=0 from the next cycle, no b_done, any pending rvalid is dropped.

Decomposition:
- Package vector_mem_pkg holds: owner_e {OWN_A, OWN_B}, state_e {ST_IDLE, ST_BURST}, VMEM_ADDR_W=9, VMEM_DATA_W=128.
- No sub-module needed. The arbitration decision is an always_comb block inside the module; a separate round-robin cell is not warranted for two requesters.

Test Plan:
- Reset, then a_req read at address 5 containing 0xAA..AA -> a_gnt in the same cycle, m_addr=5, a_rvalid=1 with a_rdata=0xAA..AA one cycle later, b_rvalid=0.
- Tie right after reset: a_req and b_req (b_len=0) asserted together -> A granted first, B next cycle. With both held continuously, grants alternate A, B, A, B.
- DMA write burst b_addr=510, b_len=3, b_req held -> m_addr 510, 511, 0, 1 on 4 consecutive cycles, b_done on the 4th, a_req raised mid-burst is granted the cycle after b_done.
- DMA read burst b_len=2 with b_req low for 2 cycles after beat 0 -> m_en gaps in those 2 cycles, 3 b_rvalid pulses total, b_done on beat 2.
- Interleave: A read at cycle n, B single-beat read at n+1 -> a_rvalid at n+1, b_rvalid at n+2, no cross-routing.
- Assert rst during beat 2 of a 16-beat burst -> m_en=0 and b_done never pulses; the next b_req restarts cleanly at the new b_addr.
